// File: rtl/button_pkg.sv
// Shared constants for the button input path: debounce FSM state encoding,
// oscillator frequency and a ceil(log2) helper for sizing counters.
package button_pkg;

    localparam logic [1:0] ST_UP      = 2'd0;
    localparam logic [1:0] ST_WAIT_DN = 2'd1;
    localparam logic [1:0] ST_DOWN    = 2'd2;
    localparam logic [1:0] ST_WAIT_UP = 2'd3;

    localparam int unsigned CLK_HZ_HFOSC = 48000000;

    // Bits needed to hold 0..value-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs; resets to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/button_reader.sv
// Debounced push-button reader: synchronizer, debounce FSM, press/release strobes, press counter.
// Define BUTTON_READER_LONG_PRESS_EN to enable long-press detection on o_long_pulse.
module button_reader
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 480000,
    parameter int unsigned LONG_CYCLES     = 48000000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn_in,
    output logic       o_pressed,
    output logic       o_press_pulse,
    output logic       o_release_pulse,
    output logic       o_long_pulse,
    output logic [7:0] o_press_count
);

    localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
        $error("button_reader: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end

    logic             w_act;
    logic             w_s2;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press_evt;
    logic             w_release_evt;
    logic             r_pressed;
    logic             r_press_pulse;
    logic             r_release_pulse;
    logic [7:0]       r_press_count;
    logic             w_long;

    assign w_act = i_btn_in ^ BTN_ACTIVE_LOW;

    sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_act),
        .o_q     (w_s2)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_evt   = 1'b0;
        w_release_evt = 1'b0;
        case (r_state)
            ST_UP: begin
                if (w_s2) begin
                    w_state_nxt = ST_WAIT_DN;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_DN: begin
                if (!w_s2) begin
                    w_state_nxt = ST_UP;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = ST_DOWN;
                    w_press_evt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DOWN: begin
                if (!w_s2) begin
                    w_state_nxt = ST_WAIT_UP;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_UP: begin
                if (w_s2) begin
                    w_state_nxt = ST_DOWN;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt   = ST_UP;
                    w_release_evt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_UP;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_UP;
            r_cnt           <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_press_count   <= 8'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_pressed       <= (w_state_nxt == ST_DOWN) || (w_state_nxt == ST_WAIT_UP);
            r_press_pulse   <= w_press_evt;
            r_release_pulse <= w_release_evt;
            if (w_press_evt) begin
                r_press_count <= r_press_count + 8'd1;
            end
        end
    end

`ifdef BUTTON_READER_LONG_PRESS_EN
    localparam int unsigned LCNT_W = clog2(LONG_CYCLES);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LONG_CYCLES - 1);

    logic [LCNT_W-1:0] r_lcnt;
    logic              r_long_done;
    logic              r_long_pulse;

    // Only an accepted press restarts the hold timer; a WAIT_UP bounce back to DOWN keeps it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lcnt       <= '0;
            r_long_done  <= 1'b0;
            r_long_pulse <= 1'b0;
        end else begin
            r_long_pulse <= 1'b0;
            if (w_press_evt) begin
                r_lcnt      <= '0;
                r_long_done <= 1'b0;
            end else if (r_state == ST_DOWN || r_state == ST_WAIT_UP) begin
                if (r_lcnt == LCNT_MAX) begin
                    if (!r_long_done) begin
                        r_long_pulse <= 1'b1;
                        r_long_done  <= 1'b1;
                    end
                end else begin
                    r_lcnt <= r_lcnt + LCNT_W'(1);
                end
            end
        end
    end

    assign w_long = r_long_pulse;
`else
    assign w_long = 1'b0;
`endif

    assign o_pressed       = r_pressed;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;
    assign o_long_pulse    = w_long;
    assign o_press_count   = r_press_count;

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: active-low and active-high instances driven with the same button
// activity, checked every cycle against a run-length model of the debounce rules.
module tb_button_reader;

    localparam int unsigned D = 4;
    localparam int unsigned L = 20;
`ifdef BUTTON_READER_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic       btn_hi;
    logic       pressed, press_pulse, release_pulse, long_pulse;
    logic [7:0] press_count;
    logic       pressed_h, press_pulse_h, release_pulse_h, long_pulse_h;
    logic [7:0] press_count_h;

    button_reader #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .BTN_ACTIVE_LOW  (1'b1)
    ) u_dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_btn_in        (btn),
        .o_pressed       (pressed),
        .o_press_pulse   (press_pulse),
        .o_release_pulse (release_pulse),
        .o_long_pulse    (long_pulse),
        .o_press_count   (press_count)
    );

    button_reader #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .BTN_ACTIVE_LOW  (1'b0)
    ) u_dut_hi (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_btn_in        (btn_hi),
        .o_pressed       (pressed_h),
        .o_press_pulse   (press_pulse_h),
        .o_release_pulse (release_pulse_h),
        .o_long_pulse    (long_pulse_h),
        .o_press_count   (press_count_h)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the accepted level flips once the synchronized input (two samples late)
    // has disagreed with it for D+1 consecutive samples.
    logic       m_s1, m_s2, m_level, m_pp, m_rp, m_lp, m_armed;
    int         m_run, m_edge, m_press_edge;
    logic [7:0] m_count;

    int g_step = 0;
    int last_pp_step = -1;
    int last_rp_step = -1;
    int last_lp_step = -1;
    int n_pp = 0;
    int n_rp = 0;
    int n_lp = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (step %0d)", tag, obs, exp, g_step);
        end
    endtask

    task automatic check_all();
        check("pressed", {7'd0, pressed}, {7'd0, m_level});
        check("press_pulse", {7'd0, press_pulse}, {7'd0, m_pp});
        check("release_pulse", {7'd0, release_pulse}, {7'd0, m_rp});
        check("long_pulse", {7'd0, long_pulse}, {7'd0, m_lp});
        check("press_count", press_count, m_count);
        check("pressed_hi", {7'd0, pressed_h}, {7'd0, m_level});
        check("press_pulse_hi", {7'd0, press_pulse_h}, {7'd0, m_pp});
        check("release_pulse_hi", {7'd0, release_pulse_h}, {7'd0, m_rp});
        check("long_pulse_hi", {7'd0, long_pulse_h}, {7'd0, m_lp});
        check("press_count_hi", press_count_h, m_count);
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_pp = 0; m_rp = 0; m_lp = 0; m_armed = 0;
        m_run = 0; m_count = 8'd0;
    endtask

    task automatic model_edge(input logic act);
        logic sample;
        sample = m_s2;
        m_s2 = m_s1;
        m_s1 = act;
        m_pp = 0; m_rp = 0; m_lp = 0;
        m_edge++;
        if (LONG_EN && m_armed && m_edge == m_press_edge + int'(L)) begin
            m_lp = 1;
            m_armed = 0;
        end
        if (sample != m_level) begin
            m_run++;
            if (m_run == int'(D) + 1) begin
                m_level = ~m_level;
                m_run = 0;
                if (m_level) begin
                    m_pp = 1;
                    m_count = m_count + 8'd1;
                    m_armed = 1;
                    m_press_edge = m_edge;
                end else begin
                    m_rp = 1;
                    m_armed = 0;
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    // One clock with the button held at logical level lvl (1 = pressed).
    task automatic step(input logic lvl);
        btn = ~lvl;
        btn_hi = lvl;
        @(posedge clk);
        if (rst_n) model_edge(lvl);
        #1;
        g_step++;
        if (press_pulse)   begin n_pp++; last_pp_step = g_step; end
        if (release_pulse) begin n_rp++; last_rp_step = g_step; end
        if (long_pulse)    begin n_lp++; last_lp_step = g_step; end
        check_all();
    endtask

    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input int cycles);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int start;
        int lvl_r;
        m_edge = 0;
        m_press_edge = 0;
        model_reset();
        rst_n = 1'b0;
        btn = 1'b1;
        btn_hi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Clean press and release: strobe in the 7th sample counted from the first changed one.
        hold(0, 5);
        start = g_step;
        hold(1, 30);
        check("clean_press_latency", 8'(last_pp_step - start), 8'd7);
        check("clean_press_count", press_count, 8'd1);
        check("clean_pressed", {7'd0, pressed}, 8'd1);
        start = g_step;
        hold(0, 20);
        check("clean_release_latency", 8'(last_rp_step - start), 8'd7);
        check("clean_released", {7'd0, pressed}, 8'd0);

        // Bounce rejected.
        start = n_pp;
        hold(1, 3); hold(0, 1); hold(1, 2); hold(0, 20);
        check("bounce_no_press", 8'(n_pp - start), 8'd0);
        check("bounce_count", press_count, 8'd1);

        // Reset mid-hold with the button still down: fresh press after full latency.
        hold(1, 10);
        hold(1, 10);
        async_reset(3);
        start = g_step;
        hold(1, 15);
        check("reset_repress_latency", 8'(last_pp_step - start), 8'd7);
        check("reset_repress_count", press_count, 8'd1);

        // Long hold: long strobe L cycles after the press strobe, once.
        hold(0, 12);
        start = n_lp;
        hold(1, 45);
        check("long_once", 8'(n_lp - start), LONG_EN ? 8'd1 : 8'd0);
        if (n_lp != start) check("long_delay", 8'(last_lp_step - last_pp_step), 8'(L));
        hold(0, 12);

        // Counter wrap over 257 presses.
        async_reset(2);
        hold(0, 8);
        n_pp = 0;
        n_rp = 0;
        for (int p = 1; p <= 257; p++) begin
            hold(1, 8);
            hold(0, 8);
            if (p == 255) check("wrap_255", press_count, 8'd255);
            if (p == 256) check("wrap_0", press_count, 8'd0);
            if (p == 257) check("wrap_1", press_count, 8'd1);
        end
        check("wrap_press_pulses", 8'(n_pp - 257), 8'd0);
        check("wrap_release_pulses", 8'(n_rp - 257), 8'd0);

        // Random runs straddling the debounce threshold, with occasional resets.
        for (int s = 0; s < 400; s++) begin
            lvl_r = int'($urandom_range(0, 1));
            hold(lvl_r[0], int'($urandom_range(1, 12)));
            if ($urandom_range(0, 39) == 0) async_reset(int'($urandom_range(1, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
- Input-side counterpart to the LED drivers: reads one raw push-button pad and produces clean, debounced events for the design logic.
- Chain: 2-FF synchronizer, then debounce FSM, then event pulses, press counter and optional long-press detection.
- Runs from the SB_HFOSC 48 MHz clock (CLKHF_DIV "0b00").
- Instantiated in the chip top next to blink, with btn_in wired to a pad.

Parameters:
- DEBOUNCE_CYCLES, 480000, number of stable samples needed to accept a level change (10 ms at 48 MHz). Must be ≥ 2.
- LONG_CYCLES, 48000000, cycles held in DOWN before long_pulse fires (1 s). Must be > DEBOUNCE_CYCLES.
- BTN_ACTIVE_LOW, 1, 1 = pad reads 0 when pressed (pull-up button); 0 = active-high.

Ports:
- clk  in  1  system clock, from SB_HFOSC CLKHF.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- btn_in  in  1  raw asynchronous button pad.
- pressed  out  1  debounced level; 1 while the button is accepted as held.
- press_pulse  out  1  one-cycle strobe on an accepted press.
- release_pulse  out  1  one-cycle strobe on an accepted release.
- long_pulse  out  1  one-cycle strobe when a long press is detected.
- press_count  out  8  count of accepted presses, wraps modulo 256.

Behaviour:
- Normalization: act = btn_in XOR BTN_ACTIVE_LOW, so act = 1 means pressed.
- Synchronizer: act passes through two flops, s1 then s2. Both reset to 0 (inactive).
- Counter: debounce counter cnt, width clog2(DEBOUNCE_CYCLES).
- FSM states and transitions:
  - UP: pressed = 0. On s2 = 1, go to WAIT_DN with cnt = 0.
  - WAIT_DN:
    - If s2 = 0, return to UP (bounce rejected, no pulse).
    - Else if cnt == DEBOUNCE_CYCLES-1, go to DOWN; in the same edge pressed = 1, press_pulse = 1, press_count += 1.
    - Else cnt += 1.
  - DOWN: pressed = 1. On s2 = 0, go to WAIT_UP with cnt = 0.
  - WAIT_UP: mirrors WAIT_DN.
    - If s2 = 1, return to DOWN.
    - At cnt == DEBOUNCE_CYCLES-1, go to UP with pressed = 0 and release_pulse = 1.
- Latency: with btn_in stable from rising edge k, press_pulse is high in the cycle after edge k+DEBOUNCE_CYCLES+2. Release latency is identical.
- Registered outputs: all outputs are registered, and pulses are exactly one cycle wide.
- Simultaneous events: press_pulse and release_pulse are never high in the same cycle. long_pulse never coincides with press_pulse.
- Wrap: press_count goes 255 to 0 on the next press, with no flag.
- Reset (any time, including mid-debounce or mid-hold):
  - State goes to UP; cnt, long counter and s1/s2 go to 0.
  - All outputs go to 0, including press_count.
  - No pulses are emitted on reset entry or exit.
  - A button held through reset release is reported as a fresh press after the full debounce latency.
- Glitches: any single-cycle inactive sample during WAIT_DN restarts debounce from UP. Glitches shorter than one sample in DOWN are filtered by the WAIT_UP return path.

Optional Feature:
- Macro: BUTTON_READER_LONG_PRESS_EN.
- With the macro:
  - Long counter lcnt, width clog2(LONG_CYCLES), clears on entry to DOWN and counts while in DOWN or WAIT_UP.
  - At lcnt == LONG_CYCLES-1 (measured from the press_pulse cycle), long_pulse fires once; lcnt then saturates.
  - No repeat until a release is accepted. A bounce back into DOWN does not clear lcnt.
- Without the macro: long_pulse is tied to 0, and no long counter logic is synthesized.

Decomposition:
- Shared package/header button_pkg:
  - 2-bit state encoding ST_UP = 0, ST_WAIT_DN = 1, ST_DOWN = 2, ST_WAIT_UP = 3.
  - Constant CLK_HZ_HFOSC = 48000000.
  - clog2 helper function.
- Sub-module sync_2ff (clk, rst, d, q) for the synchronizer, reusable for other pad inputs.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, BTN_ACTIVE_LOW=1):
- Clean press: btn_in 1 to 0 held 30 cycles.
  - press_pulse high for exactly one cycle, 6 cycles after the first low sample.
  - pressed = 1, press_count = 1.
  - Release then gives release_pulse after 6 cycles and pressed = 0.
- Bounce: btn_in low 3 cycles, high 1 cycle, low 2 cycles, high.
  - No pulses, pressed stays 0, press_count = 0.
- Wrap: 256 clean presses, then 1 more.
  - press_count reads 255, then 0, then 1.
  - Exactly 257 press_pulse and 257 release_pulse strobes.
- Reset mid-hold: press accepted, hold 10 cycles, assert rst for 3 cycles asynchronously (between edges) while btn_in stays low.
  - Outputs go to 0 immediately.
  - After release of rst, press_pulse fires again after 6 cycles and press_count = 1.
- Long press (macro on): hold 40 cycles.
  - long_pulse exactly once, 20 cycles after press_pulse.
  - Without the macro, long_pulse stays 0 throughout.
- Active-high build (BTN_ACTIVE_LOW=0): btn_in 0 to 1 held.
  - Same timing as the clean-press case.
  - btn_in stuck at 0 never produces a pulse.
